// File: rtl/doser_pkg.sv
// doser_pkg: shared state/ingredient types, default dose lengths and
// small decode helpers for ingredient_doser and its dose_counter.
package doser_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DOSE  = 3'd1,
        DONE  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    // Ingredient index; also the bit position of the matching valve.
    typedef enum logic [2:0] {
        WATER  = 3'd0,
        COFFEE = 3'd1,
        SUGAR  = 3'd2,
        MILK   = 3'd3,
        CHOC   = 3'd4
    } ingredient_t;

    // Five ingredient requests plus the 'finished' request.
    localparam int NUM_INGR = 5;
    localparam int NUM_REQ  = 6;

    // Default counter width and dose lengths (in ticks).
    localparam int DEF_CW          = 8;
    localparam int DEF_DOSE_WATER  = 200;
    localparam int DEF_DOSE_COFFEE = 50;
    localparam int DEF_DOSE_SUGAR  = 20;
    localparam int DEF_DOSE_MILK   = 40;
    localparam int DEF_DOSE_CHOC   = 30;

    // Number of asserted request lines; saturation is unnecessary since
    // six lines fit in three bits.
    function automatic logic [2:0] count_ones(input logic [NUM_REQ-1:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            n = n + 3'(v[i]);
        end
        return n;
    endfunction

    // Index of the (assumed single) set bit of an ingredient request vector.
    function automatic ingredient_t onehot_to_ingr(input logic [NUM_INGR-1:0] v);
        ingredient_t r;
        r = WATER;
        for (int i = 0; i < NUM_INGR; i++) begin
            if (v[i]) begin
                r = ingredient_t'(3'(i));
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/dose_counter.sv
// dose_counter: loadable down-counter for the dose length. Counts one step
// per tick while 'run' is high and never wraps below zero.
// Build option: DOSER_PRESCALE_EN adds a prescaler so a tick happens only
// once every PRESCALE run cycles; without it every run cycle is a tick.
module dose_counter
    import doser_pkg::*;
#(
    parameter int CW = DEF_CW
`ifdef DOSER_PRESCALE_EN
    ,
    parameter int PRESCALE = 4
`endif
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          run,
    output logic          last_tick,
    output logic          zero
);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          tick;

`ifdef DOSER_PRESCALE_EN
    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_reg;
    logic [PW-1:0] pre_next;

    // Prescaler restarts on every load so each dose begins a full period.
    always_comb begin
        pre_next = pre_reg;
        if (load) begin
            pre_next = '0;
        end else if (run) begin
            pre_next = (pre_reg == PRE_MAX) ? '0 : pre_reg + PW'(1);
        end
    end

    // Prescaler register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pre_reg <= '0;
        end else begin
            pre_reg <= pre_next;
        end
    end

    assign tick = run && (pre_reg == PRE_MAX);
`else
    assign tick = run;
`endif

    // Load has priority; decrements are suppressed at zero.
    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_value;
        end else if (tick && (count_reg != '0)) begin
            count_next = count_reg - CW'(1);
        end
    end

    // Dose counter register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign zero      = (count_reg == '0);
    assign last_tick = tick && (count_reg == CW'(1));

endmodule

// File: rtl/ingredient_doser.sv
// ingredient_doser: opens one ingredient valve for a fixed number of ticks
// per one-hot request, pulses 'result' when the dose completes, and locks
// into a sticky fault on any protocol violation until reset.
// Build option: DOSER_PRESCALE_EN enables the PRESCALE tick divider.
module ingredient_doser
    import doser_pkg::*;
#(
    parameter int            CW          = DEF_CW,
    parameter logic [CW-1:0] DOSE_WATER  = CW'(DEF_DOSE_WATER),
    parameter logic [CW-1:0] DOSE_COFFEE = CW'(DEF_DOSE_COFFEE),
    parameter logic [CW-1:0] DOSE_SUGAR  = CW'(DEF_DOSE_SUGAR),
    parameter logic [CW-1:0] DOSE_MILK   = CW'(DEF_DOSE_MILK),
    parameter logic [CW-1:0] DOSE_CHOC   = CW'(DEF_DOSE_CHOC)
`ifdef DOSER_PRESCALE_EN
    ,
    parameter int            PRESCALE    = 4
`endif
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       water,
    input  logic       coffee,
    input  logic       sugar,
    input  logic       milk,
    input  logic       chocolate,
    input  logic       finished,
    output logic       result,
    output logic [4:0] valve,
    output logic       busy,
    output logic       fault
);

    state_t             state_reg;
    state_t             state_next;
    ingredient_t        idx_reg;
    ingredient_t        idx_next;

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] latched_code;
    logic [2:0]         req_ones;
    ingredient_t        req_idx;
    logic [CW-1:0]      sel_dose;
    logic               code_mismatch;

    logic               cnt_load;
    logic               cnt_run;
    logic               cnt_last;
    logic               cnt_zero;

    // Request vector in valve bit order, 'finished' on top.
    assign req_vec  = {finished, chocolate, milk, sugar, coffee, water};
    assign req_ones = count_ones(req_vec);
    assign req_idx  = onehot_to_ingr(req_vec[NUM_INGR-1:0]);

    // Code the sequencer must keep presenting while the latched ingredient
    // is being dosed or held; 'finished' is never part of it.
    for (genvar gi = 0; gi < NUM_INGR; gi++) begin : g_code
        assign latched_code[gi] = (idx_reg == ingredient_t'(3'(gi)));
    end
    assign latched_code[NUM_REQ-1] = 1'b0;

    assign code_mismatch = (req_vec != latched_code);

    // Dose length of the ingredient currently requested.
    always_comb begin
        sel_dose = DOSE_WATER;
        case (req_idx)
            WATER:   sel_dose = DOSE_WATER;
            COFFEE:  sel_dose = DOSE_COFFEE;
            SUGAR:   sel_dose = DOSE_SUGAR;
            MILK:    sel_dose = DOSE_MILK;
            CHOC:    sel_dose = DOSE_CHOC;
            default: sel_dose = DOSE_WATER;
        endcase
    end

    dose_counter #(
        .CW(CW)
`ifdef DOSER_PRESCALE_EN
        ,
        .PRESCALE(PRESCALE)
`endif
    ) u_counter (
        .clock      (clock),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (sel_dose),
        .run        (cnt_run),
        .last_tick  (cnt_last),
        .zero       (cnt_zero)
    );

    // State and latched ingredient registers, synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg <= IDLE;
            idx_reg   <= WATER;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Next-state decode and Moore/Mealy outputs; the valve drops in the same
    // cycle a DOSE-time request change is seen.
    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_load   = 1'b0;
        cnt_run    = 1'b0;
        valve      = '0;
        result     = 1'b0;
        busy       = 1'b0;
        fault      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (req_ones >= 3'd2) begin
                    state_next = FAULT;
                end else if ((req_ones == 3'd1) && !finished) begin
                    idx_next   = req_idx;
                    cnt_load   = 1'b1;
                    // A zero-length dose skips the valve entirely.
                    state_next = (sel_dose == '0) ? DONE : DOSE;
                end
            end

            DOSE: begin
                busy = 1'b1;
                if (code_mismatch) begin
                    state_next = FAULT;
                end else begin
                    valve   = latched_code[NUM_INGR-1:0];
                    cnt_run = 1'b1;
                    if (cnt_last || cnt_zero) begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                busy       = 1'b1;
                result     = 1'b1;
                state_next = HOLD;
            end

            HOLD: begin
                busy = 1'b1;
                // Wait for the sequencer to move on so a held request is
                // never dosed twice.
                if (code_mismatch) begin
                    state_next = IDLE;
                end
            end

            FAULT: begin
                fault = 1'b1;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ingredient_doser.sv
// tb_ingredient_doser: directed bench for ingredient_doser. Expected valve
// runs are queued as requests are driven and compared when each run ends.
module tb_ingredient_doser;

`ifdef DOSER_PRESCALE_EN
    localparam int TP = 4;
`else
    localparam int TP = 1;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       water, coffee, sugar, milk, chocolate, finished;
    logic       result;
    logic [4:0] valve;
    logic       busy, fault;

    logic       b_water, b_coffee, b_sugar, b_milk, b_chocolate, b_finished;
    logic       b_result;
    logic [4:0] b_valve;
    logic       b_busy, b_fault;

    ingredient_doser #(
        .CW(8), .DOSE_WATER(8'd3), .DOSE_COFFEE(8'd2), .DOSE_SUGAR(8'd1),
        .DOSE_MILK(8'd2), .DOSE_CHOC(8'd1)
    ) dut_a (
        .clock(clock), .reset(reset), .water(water), .coffee(coffee),
        .sugar(sugar), .milk(milk), .chocolate(chocolate), .finished(finished),
        .result(result), .valve(valve), .busy(busy), .fault(fault)
    );

    ingredient_doser #(
        .CW(8), .DOSE_WATER(8'd3), .DOSE_COFFEE(8'd2), .DOSE_SUGAR(8'd0),
        .DOSE_MILK(8'd2), .DOSE_CHOC(8'd1)
    ) dut_b (
        .clock(clock), .reset(reset), .water(b_water), .coffee(b_coffee),
        .sugar(b_sugar), .milk(b_milk), .chocolate(b_chocolate), .finished(b_finished),
        .result(b_result), .valve(b_valve), .busy(b_busy), .fault(b_fault)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0] val;
        int         len;
    } run_t;

    run_t exp_q[$];
    int   vectors      = 0;
    int   miscompares  = 0;
    int   run_len      = 0;
    logic [4:0] run_val = '0;
    int   res_len      = 0;
    bit   res_seen     = 1'b0;
    int   result_count = 0;
    bit   b_sugar_seen = 1'b0;
    int   dose_len [5] = '{3, 2, 1, 2, 1};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tracks valve runs and result pulses of dut_a, valve[2] of dut_b.
    task automatic monitor();
        run_t e;
        if (valve !== 5'd0) begin
            if (run_len == 0) run_val = valve;
            run_len++;
        end else if (run_len > 0) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $error("FAIL unexpected_run: observed valve %b for %0d cycles, expected none", run_val, run_len);
            end else begin
                e = exp_q.pop_front();
                check("run_valve", 32'(run_val), 32'(e.val));
                check("run_len", 32'(run_len), 32'(e.len));
            end
            $display("run: valve=%b cycles=%0d", run_val, run_len);
            run_len = 0;
        end
        if (result === 1'b1) begin
            res_len++;
            res_seen = 1'b1;
        end else if (res_len > 0) begin
            check("result_width", 32'(res_len), 32'd1);
            result_count++;
            res_len = 0;
        end
        if (b_valve[2] === 1'b1) b_sugar_seen = 1'b1;
    endtask

    task automatic step();
        @(negedge clock);
        monitor();
    endtask

    task automatic set_req(input logic [5:0] v);
        {finished, chocolate, milk, sugar, coffee, water} = v;
    endtask

    task automatic set_b(input logic [5:0] v);
        {b_finished, b_chocolate, b_milk, b_sugar, b_coffee, b_water} = v;
    endtask

    task automatic push_run(input int idx, input int len);
        run_t e;
        e.val = 5'b00001 << idx;
        e.len = len;
        exp_q.push_back(e);
    endtask

    task automatic wait_result(input string tag);
        int n;
        n = 0;
        res_seen = 1'b0;
        while (!res_seen && n < 200) begin
            step();
            n++;
        end
        if (!res_seen) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_timeout: observed no result in %0d cycles, expected a pulse", tag, n);
        end
    endtask

    initial begin
        set_req(6'd0);
        set_b(6'd0);
        reset = 1'b0;
        step();
        step();
        check("rst_valve", 32'(valve), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_b_busy", 32'(b_busy), 32'd0);
        reset = 1'b1;

        // Full recipe: next request issued as soon as each result appears.
        for (int i = 0; i < 5; i++) begin
            set_req(6'b000001 << i);
            push_run(i, dose_len[i] * TP);
            wait_result("recipe");
        end
        set_req(6'b100000);
        repeat (4) step();
        check("recipe_results", 32'(result_count), 32'd5);
        check("recipe_queue_empty", 32'(exp_q.size()), 32'd0);

        // Held request is not re-dosed; a switch starts 2 cycles later.
        set_req(6'b000001);
        push_run(0, 3 * TP);
        wait_result("hold_water");
        step();
        repeat (5) begin
            step();
            check("hold_valve", 32'(valve), 32'd0);
        end
        check("hold_busy", 32'(busy), 32'd1);
        set_req(6'b000010);
        push_run(1, 2 * TP);
        step();
        check("switch_idle_valve", 32'(valve), 32'd0);
        step();
        check("switch_dose_valve", 32'(valve), 32'b00010);
        wait_result("switch_coffee");
        set_req(6'd0);
        repeat (3) step();

        // Reset in the middle of a water dose, then a fresh full dose.
        set_req(6'b000001);
        push_run(0, 2);
        step();
        step();
        reset = 1'b0;
        step();
        check("midrst_valve", 32'(valve), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        push_run(0, 3 * TP);
        step();
        check("midrst_restart_valve", 32'(valve), 32'b00001);
        wait_result("midrst_full");
        set_req(6'd0);
        repeat (3) step();

        // Two requests at once in IDLE: sticky fault until reset.
        set_req(6'b000011);
        step();
        check("multi_fault", 32'(fault), 32'd1);
        check("multi_valve", 32'(valve), 32'd0);
        check("multi_busy", 32'(busy), 32'd0);
        set_req(6'b000001);
        repeat (4) step();
        check("fault_sticky", 32'(fault), 32'd1);
        check("fault_sticky_valve", 32'(valve), 32'd0);
        reset = 1'b0;
        step();
        check("fault_cleared", 32'(fault), 32'd0);
        reset = 1'b1;
        set_req(6'd0);
        step();

        // Request change while dosing: fault and valve drop.
        set_req(6'b001000);
        push_run(3, 1);
        step();
        set_req(6'b000100);
        step();
        check("dose_change_fault", 32'(fault), 32'd1);
        check("dose_change_valve", 32'(valve), 32'd0);
        reset = 1'b0;
        set_req(6'd0);
        step();
        reset = 1'b1;
        step();

        // Zero-length sugar dose on the second instance.
        set_b(6'b000100);
        step();
        check("zero_dose_result", 32'(b_result), 32'd1);
        check("zero_dose_valve", 32'(b_valve), 32'd0);
        step();
        check("zero_dose_result_end", 32'(b_result), 32'd0);
        check("zero_dose_hold_busy", 32'(b_busy), 32'd1);
        set_b(6'd0);
        step();
        check("zero_dose_idle_busy", 32'(b_busy), 32'd0);
        check("zero_dose_no_valve", 32'(b_sugar_seen), 32'd0);

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_results", 32'(result_count), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ingredient_doser.md
INGREDIENT_DOSER -- requirements
Module: ingredient_doser

Interface
REQ-001 Parameter CW, default 8: width of dose counter and dose constants.
REQ-002 Parameters DOSE_WATER/DOSE_COFFEE/DOSE_SUGAR/DOSE_MILK/DOSE_CHOC, defaults 200/50/20/40/30: dose length per ingredient in ticks; each is CW bits.
REQ-003 clock  input  1  sole clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 water, coffee, sugar, milk, chocolate, finished  input  1 each  one-hot step request from the sequencing FSM.
REQ-006 result  output  1  one-cycle pulse: current ingredient dose complete.
REQ-007 valve  output  5  one-hot valve drive; bits 0..4 are water, coffee, sugar, milk, chocolate.
REQ-008 busy  output  1  high in DOSE, DONE and HOLD states.
REQ-009 fault  output  1  sticky protocol-error flag.

Function
REQ-010 States SHALL be IDLE, DOSE, DONE, HOLD and FAULT.
REQ-011 IDLE, exactly one ingredient input high and finished low: latch the ingredient index, load its dose into the counter, go to DOSE. If the dose is 0, go directly to DONE.
REQ-012 IDLE, all six inputs low, or only finished high: stay in IDLE; valve=0, result=0.
REQ-013 IDLE, two or more of the six inputs high: go to FAULT.
REQ-014 DOSE: drive the latched valve bit high and decrement the counter once per tick. Ticks occur every cycle unless REQ-024 applies.
REQ-015 The valve bit SHALL be high for exactly dose×tick-period cycles, starting the cycle after the IDLE decision.
REQ-016 DOSE, decrement from 1 to 0: go to DONE; the valve is low from the DONE cycle onward.
REQ-017 DONE: result=1 for exactly one cycle, then go to HOLD.
REQ-018 HOLD: result=0 and valve=0. Return to IDLE when the input vector differs from the latched code, so the same ingredient is never re-dosed.
REQ-019 DOSE: if the input vector differs from the latched code, go to FAULT and drop the valve the same cycle.
REQ-020 FAULT: valve=0, result=0, fault=1. It SHALL remain in FAULT until reset.
REQ-021 The counter SHALL never underflow. Its arithmetic is unsigned, CW bits.

Reset
REQ-022 When reset=0 at a clock edge, the block SHALL enter IDLE with counter=0, latched index=0, prescaler=0, valve=0, result=0, busy=0 and fault=0. This applies in every state, including mid-dose and FAULT.
REQ-023 In the first cycle after reset release, the block SHALL evaluate inputs per REQ-011 to REQ-013.

Configuration
REQ-024 With DOSER_PRESCALE_EN defined: parameter PRESCALE (default 4, ≥1) SHALL gate ticks to one every PRESCALE cycles. The prescaler clears on entry to DOSE, and the valve is high for dose×PRESCALE cycles.
REQ-025 Without DOSER_PRESCALE_EN: no prescaler logic exists, PRESCALE is ignored, and the counter ticks every cycle.

Structure
REQ-026 Package doser_pkg SHALL hold the state enum, the ingredient index enum (WATER=0..CHOC=4) and the default dose constants.
REQ-027 Sub-module dose_counter (load, tick, zero flag, CW-wide; prescaler included under the macro) SHALL be instantiated once.

Verification
REQ-028 Doses 3/2/1/2/1, FSM model looping on result: the valve sequence SHALL be 3,2,1,2,1 cycles, with 5 result pulses, each one cycle wide.
REQ-029 DOSE_SUGAR=0, sugar high: result SHALL pulse 1 cycle after the IDLE decision, and valve[2] SHALL never assert.
REQ-030 water and coffee high together in IDLE: fault=1 the next cycle and the valve stays 0. Fault SHALL persist until reset=0, then clear.
REQ-031 reset=0 on the 2nd valve cycle of a 3-tick dose: next cycle valve=0 and busy=0; after release, water held high SHALL start a full 3-cycle dose.
REQ-032 Water held high after result: no second dose. A switch to coffee SHALL start the coffee dose 2 cycles after the switch (HOLD→IDLE→DOSE).
REQ-033 DOSER_PRESCALE_EN, PRESCALE=4, DOSE_MILK=2: valve[3] SHALL be high for 8 cycles, then 1 result pulse.
